// File: rtl/rr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// rr_burst_arbiter
//   Round-robin burst arbiter. Produces the one-hot select word for a one-hot
//   AND-OR mux. One requester is granted at a time. The grant is held for
//   len+1 accepted beats and then released for one idle cycle. After that the
//   arbiter re-arbitrates, starting the scan at the port after the last winner.
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   req_valid     in   [PORT_NUM]            per-port request / beat valid
//   req_len       in   [PORT_NUM*LEN_WIDTH]  per-port burst length-1
//   req_ready     out  [PORT_NUM]            beat accepted = grant & out_ready
//   grant_onehot  out  [PORT_NUM]            registered one-hot grant, 0 when idle
//   out_valid     out                        granted port has a valid beat
//   out_ready     in                         downstream accepts current beat
//   burst_done    out                        1-cycle pulse after the last beat
//   busy          out                        high while a burst is in flight
// -----------------------------------------------------------------------------
module rr_burst_arbiter #(
   parameter int PORT_NUM  = 3,
   parameter int LEN_WIDTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [PORT_NUM-1:0]           req_valid,
   input  logic [PORT_NUM*LEN_WIDTH-1:0] req_len,
   output logic [PORT_NUM-1:0]           req_ready,
   output logic [PORT_NUM-1:0]           grant_onehot,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          burst_done,
   output logic                          busy
);

   localparam int                PTR_W   = $clog2(PORT_NUM);
   localparam logic [PTR_W:0]    LP_NUM  = (PTR_W+1)'(PORT_NUM);
   localparam logic [PTR_W-1:0]  LP_LAST = PTR_W'(PORT_NUM - 1);

   typedef enum logic {
      ST_IDLE,
      ST_BURST
   } state_t;

   state_t                r_state;
   logic [PORT_NUM-1:0]   r_grant;
   logic [LEN_WIDTH-1:0]  r_cnt;      // beats remaining after the current one
   logic [PTR_W-1:0]      r_ptr;      // highest-priority port for next arbitration
   logic [PTR_W-1:0]      r_winner;   // index of the port holding the grant
   logic                  r_done;

   logic                  w_found;
   logic [PTR_W-1:0]      w_win_idx;
   logic [PORT_NUM-1:0]   w_win_oh;
   logic [PTR_W:0]        w_sum;
   logic                  w_beat;

   // Scan from r_ptr upward, wrapping at PORT_NUM-1. The first asserted
   // request wins.
   always_comb begin
      // NOTE: every variable gets a default before any conditional assignment,
      // so no path leaves it unassigned and no latch is inferred.
      w_found   = 1'b0;
      w_win_idx = '0;
      w_win_oh  = '0;
      w_sum     = '0;
      for (int k = 0; k < PORT_NUM; k++) begin
         w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
         if (w_sum >= LP_NUM) begin
            w_sum = w_sum - LP_NUM;
         end
         if (!w_found && req_valid[w_sum[PTR_W-1:0]]) begin
            w_found   = 1'b1;
            w_win_idx = w_sum[PTR_W-1:0];
         end
      end
      for (int i = 0; i < PORT_NUM; i++) begin
         w_win_oh[i] = w_found && (w_win_idx == PTR_W'(i));
      end
   end

   // Outputs combinational from the registered grant only.
   assign out_valid    = |(r_grant & req_valid);
   assign req_ready    = r_grant & {PORT_NUM{out_ready}};
   assign w_beat       = out_valid & out_ready;
   assign grant_onehot = r_grant;
   assign burst_done   = r_done;
   assign busy         = (r_state == ST_BURST);

   // NOTE: the reset is asynchronous, so a reset mid-burst drops the grant
   // at once without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_grant  <= '0;
         r_cnt    <= '0;
         r_ptr    <= '0;
         r_winner <= '0;
         r_done   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments. Every register updates from
         // pre-edge values, whatever the statement order.
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_grant  <= w_win_oh;
                  // Length is captured here only. Later changes do not
                  // affect this burst.
                  r_cnt    <= req_len[w_win_idx*LEN_WIDTH +: LEN_WIDTH];
                  r_winner <= w_win_idx;
                  r_state  <= ST_BURST;
               end
            end
            ST_BURST: begin
               if (w_beat) begin
                  if (r_cnt != '0) begin
                     r_cnt <= r_cnt - 1'b1;
                  end else begin
                     r_grant <= '0;
                     r_done  <= 1'b1;
                     r_ptr   <= (r_winner == LP_LAST) ? '0 : r_winner + 1'b1;
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: begin
               r_grant <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_burst_arbiter
//   Directed self-checking bench for rr_burst_arbiter (PORT_NUM=3,
//   LEN_WIDTH=4). Each burst's expected port and beat count are queued when
//   the stimulus is driven. A negedge monitor pops an entry on every
//   burst_done and compares it with the grant and beats it observed.
//   Inputs change 1 time unit after the rising edge. Outputs are sampled on
//   the falling edge.
// -----------------------------------------------------------------------------
module tb_rr_burst_arbiter;

   localparam int PN = 3;
   localparam int LW = 4;

   typedef struct {
      logic [PN-1:0] grant;
      int            beats;
   } burst_t;

   localparam logic [PN-1:0] FAIR_G [8] = '{3'b001, 3'b000, 3'b010, 3'b000,
                                            3'b100, 3'b000, 3'b001, 3'b000};
   localparam logic          FAIR_D [8] = '{1'b0, 1'b1, 1'b0, 1'b1,
                                            1'b0, 1'b1, 1'b0, 1'b1};
   localparam logic          BP_RDY [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   localparam logic [PN-1:0] BP_RR  [4] = '{3'b000, 3'b010, 3'b000, 3'b010};

   logic                clk;
   logic                rst_n;
   logic [PN-1:0]       req_valid;
   logic [PN*LW-1:0]    req_len;
   logic [PN-1:0]       req_ready;
   logic [PN-1:0]       grant_onehot;
   logic                out_valid;
   logic                out_ready;
   logic                burst_done;
   logic                busy;

   int                  n_checks = 0;
   int                  n_errors = 0;
   burst_t              exp_q[$];

   // Monitor state
   logic [PN-1:0]       trk_grant = '0;
   int                  trk_beats = 0;

   rr_burst_arbiter #(
      .PORT_NUM  (PN),
      .LEN_WIDTH (LW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_len      (req_len),
      .req_ready    (req_ready),
      .grant_onehot (grant_onehot),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .burst_done   (burst_done),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc_check(input string tag, input logic [PN-1:0] eg, input logic ed);
      @(negedge clk);
      check({tag, "_grant"}, 32'(grant_onehot), 32'(eg));
      check({tag, "_done"},  32'(burst_done),   32'(ed));
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!rst_n) begin
         trk_grant = '0;
         trk_beats = 0;
      end else begin
         check("onehot", 32'($onehot0(grant_onehot)), 32'd1);
         if (burst_done) begin
            check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               burst_t e;
               e = exp_q.pop_front();
               check("sb_grant", 32'(trk_grant), 32'(e.grant));
               check("sb_beats", 32'(trk_beats), 32'(e.beats));
            end
            trk_grant = '0;
            trk_beats = 0;
         end
         if (grant_onehot != '0) begin
            if (trk_grant == '0) begin
               trk_grant = grant_onehot;
            end else begin
               check("grant_hold", 32'(grant_onehot), 32'(trk_grant));
            end
            if (out_valid && out_ready) begin
               trk_beats++;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_len   = '0;
      out_ready = 1'b0;

      // ---- Reset state ----
      @(negedge clk);
      check("rst_grant", 32'(grant_onehot), 32'd0);
      check("rst_busy",  32'(busy),         32'd0);
      check("rst_done",  32'(burst_done),   32'd0);
      check("rst_ready", 32'(req_ready),    32'd0);
      next_cycle();
      req_valid = 3'b111;
      out_ready = 1'b1;
      @(negedge clk);
      check("rst_hold_grant", 32'(grant_onehot), 32'd0);
      next_cycle();
      rst_n     = 1'b1;
      req_valid = '0;
      out_ready = 1'b0;
      cyc_check("idle", 3'b000, 1'b0);

      // ---- Single port, len=2 ----
      next_cycle();
      req_len[1*LW +: LW] = 4'd2;
      req_valid = 3'b010;
      out_ready = 1'b1;
      exp_q.push_back('{grant: 3'b010, beats: 3});
      next_cycle();
      @(negedge clk);
      check("single_c1_grant", 32'(grant_onehot), 32'b010);
      check("single_c1_busy",  32'(busy),         32'd1);
      check("single_c1_valid", 32'(out_valid),    32'd1);
      check("single_c1_ready", 32'(req_ready),    32'b010);
      next_cycle();
      cyc_check("single_c2", 3'b010, 1'b0);
      next_cycle();
      cyc_check("single_c3", 3'b010, 1'b0);
      next_cycle();
      req_valid = '0;
      cyc_check("single_c4", 3'b000, 1'b1);
      check("single_c4_busy", 32'(busy), 32'd0);
      next_cycle();
      cyc_check("single_c5", 3'b000, 1'b0);

      // ---- Fairness from pointer 0 ----
      next_cycle();
      rst_n = 1'b0;
      #1;
      check("ptr_rst_grant", 32'(grant_onehot), 32'd0);
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      req_len   = '0;
      req_valid = 3'b111;
      out_ready = 1'b1;
      exp_q.push_back('{grant: 3'b001, beats: 1});
      exp_q.push_back('{grant: 3'b010, beats: 1});
      exp_q.push_back('{grant: 3'b100, beats: 1});
      exp_q.push_back('{grant: 3'b001, beats: 1});
      for (int c = 1; c <= 8; c++) begin
         next_cycle();
         if (c == 8) req_valid = '0;
         cyc_check("fair", FAIR_G[c-1], FAIR_D[c-1]);
      end
      next_cycle();
      cyc_check("fair_idle", 3'b000, 1'b0);

      // ---- Backpressure: port1 len=1, out_ready 0,1,0,1 ----
      next_cycle();
      req_len[1*LW +: LW] = 4'd1;
      req_valid = 3'b010;
      out_ready = 1'b0;
      exp_q.push_back('{grant: 3'b010, beats: 2});
      for (int c = 1; c <= 4; c++) begin
         next_cycle();
         out_ready = BP_RDY[c-1];
         @(negedge clk);
         check("bp_grant", 32'(grant_onehot), 32'b010);
         check("bp_ready", 32'(req_ready),    32'(BP_RR[c-1]));
      end
      next_cycle();
      req_valid = '0;
      out_ready = 1'b0;
      cyc_check("bp_release", 3'b000, 1'b1);

      // ---- Reset mid-burst, then full 16-beat burst ----
      next_cycle();
      req_len[0 +: LW] = 4'd15;
      req_valid = 3'b001;
      out_ready = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         next_cycle();
         @(negedge clk);
         check("abort_pre_grant", 32'(grant_onehot), 32'b001);
      end
      next_cycle();
      rst_n = 1'b0;
      #1;
      check("abort_async_grant", 32'(grant_onehot), 32'd0);
      check("abort_async_busy",  32'(busy),         32'd0);
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_rel_grant", 32'(grant_onehot), 32'd0);
      exp_q.push_back('{grant: 3'b001, beats: 16});
      for (int c = 8; c <= 23; c++) begin
         next_cycle();
         cyc_check("full_hold", 3'b001, 1'b0);
      end
      next_cycle();
      req_valid = '0;
      cyc_check("full_end", 3'b000, 1'b1);

      // ---- Valid gap on port2, port0 waits ----
      next_cycle();
      req_len[2*LW +: LW] = 4'd3;
      req_len[0 +: LW]    = 4'd0;
      req_valid = 3'b100;
      out_ready = 1'b1;
      exp_q.push_back('{grant: 3'b100, beats: 4});
      exp_q.push_back('{grant: 3'b001, beats: 1});
      next_cycle();
      @(negedge clk);
      check("gap_c1_grant", 32'(grant_onehot), 32'b100);
      check("gap_c1_valid", 32'(out_valid),    32'd1);
      next_cycle();
      req_len[2*LW +: LW] = 4'd0;
      cyc_check("gap_c2", 3'b100, 1'b0);
      next_cycle();
      req_valid = 3'b001;
      @(negedge clk);
      check("gap_c3_valid", 32'(out_valid),    32'd0);
      check("gap_c3_grant", 32'(grant_onehot), 32'b100);
      next_cycle();
      @(negedge clk);
      check("gap_c4_valid", 32'(out_valid),    32'd0);
      check("gap_c4_grant", 32'(grant_onehot), 32'b100);
      next_cycle();
      req_valid = 3'b101;
      @(negedge clk);
      check("gap_c5_valid", 32'(out_valid),    32'd1);
      check("gap_c5_grant", 32'(grant_onehot), 32'b100);
      next_cycle();
      cyc_check("gap_c6", 3'b100, 1'b0);
      next_cycle();
      req_valid = 3'b001;
      cyc_check("gap_c7", 3'b000, 1'b1);
      next_cycle();
      cyc_check("gap_c8", 3'b001, 1'b0);
      next_cycle();
      req_valid = '0;
      cyc_check("gap_c9", 3'b000, 1'b1);

      next_cycle();
      next_cycle();
      @(negedge clk);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
